// File: rtl/tb_uart.sv
// rtl/tb_uart.sv - 8N1 LSB-first UART transceiver used as the SoC's bench-side serial partner
module tb_uart #(
  parameter int CLK_DIV = 4167
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ser_rx,
  output logic       ser_tx,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_clear_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DIV_HALF = CW'(CLK_DIV / 2);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // ---------------------------------------------------------------- TX
  state_t          tx_state_q, tx_state_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            tx_start_q;
  logic            ser_tx_q, ser_tx_d;
  logic            tx_busy_q, tx_busy_d;
  logic            tx_edge;
  logic            tx_accept;

  assign tx_edge = tx_start & ~tx_start_q;

  // TX next state: one bit period per state/bit, shifting LSB first
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_accept  = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        if (tx_edge) begin
          tx_accept  = 1'b1;
          tx_shift_d = tx_data;
          tx_cnt_d   = '0;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        if (tx_cnt_q == DIV_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
          tx_state_d = S_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (tx_cnt_q == DIV_LAST) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) begin
            tx_state_d = S_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (tx_cnt_q == DIV_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = S_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase

    // Line level and busy are registered from the next state so the pad never glitches
    case (tx_state_d)
      S_START: ser_tx_d = 1'b0;
      S_DATA:  ser_tx_d = tx_shift_d[0];
      default: ser_tx_d = 1'b1;
    endcase
    tx_busy_d = (tx_state_d != S_IDLE);
  end

  // TX state register and start-edge history
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      tx_start_q <= 1'b0;
      ser_tx_q   <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_start_q <= tx_start;
      ser_tx_q   <= ser_tx_d;
      tx_busy_q  <= tx_busy_d;
    end
  end

  assign ser_tx  = ser_tx_q;
  assign tx_busy = tx_busy_q;

  // ---------------------------------------------------------------- RX
  state_t          rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_s1_q, rx_s2_q, rx_prev_q;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_good, rx_bad;
  logic            clear_q, clear_d;

  // RX next state: half-bit start qualification, then mid-bit sampling
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_good    = 1'b0;
    rx_bad     = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_cnt_d   = '0;
          rx_state_d = S_START;
        end
      end
      S_START: begin
        if (rx_cnt_q == DIV_HALF) begin
          rx_cnt_d = '0;
          rx_bit_d = 3'd0;
          // A line that has already returned high was a glitch, not a start bit
          rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == DIV_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = S_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (rx_cnt_q == DIV_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = S_IDLE;
          if (rx_s2_q) begin
            rx_good   = 1'b1;
            rx_data_d = rx_shift_q;
          end else begin
            rx_bad = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase

    // A received byte wins over a simultaneous transmit acceptance
    clear_d = clear_q;
    if (tx_accept) clear_d = 1'b0;
    if (rx_good)   clear_d = 1'b1;
  end

  // RX synchronizer, state register and result flags
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_valid   <= 1'b0;
      rx_err     <= 1'b0;
      clear_q    <= 1'b0;
    end else begin
      rx_s1_q    <= ser_rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid   <= rx_good;
      rx_err     <= rx_bad;
      clear_q    <= clear_d;
    end
  end

  assign rx_data      = rx_data_q;
  assign tx_clear_req = clear_q;

endmodule

// File: tb/tb_tb_uart.sv
// tb/tb_tb_uart.sv - self-checking bench for the tb_uart transceiver
module tb_tb_uart;

  localparam int D = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       ser_rx;
  logic       ser_tx;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_clear_req;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;

  logic loop_en;
  logic drv_rx;

  int pass_cnt = 0;
  int total_cnt = 0;
  int vcount = 0;
  int ecount = 0;
  int busy_rises = 0;
  logic busy_prev = 1'b0;
  logic [7:0] exp_q[$];

  assign ser_rx = loop_en ? ser_tx : drv_rx;

  tb_uart #(.CLK_DIV(D)) dut (
    .clock        (clock),
    .reset        (reset),
    .ser_rx       (ser_rx),
    .ser_tx       (ser_tx),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_busy      (tx_busy),
    .tx_clear_req (tx_clear_req),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_err       (rx_err)
  );

  always #5 clock = ~clock;

  // Event counters sampled away from the active edge
  always @(negedge clock) begin
    if (rx_valid) vcount = vcount + 1;
    if (rx_err) ecount = ecount + 1;
    if (tx_busy && !busy_prev) busy_rises = busy_rises + 1;
    busy_prev = tx_busy;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    tx_data = b;
    tx_start = 1'b1;
    @(negedge clock);
    tx_start = 1'b0;
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      drv_rx = f[k];
      repeat (D) @(negedge clock);
    end
    drv_rx = 1'b1;
  endtask

  task automatic wait_rx(input string name);
    logic got;
    logic [7:0] e;
    got = 1'b0;
    for (int i = 0; i < 12 * D + 40; i++) begin
      @(negedge clock);
      if (rx_valid) begin
        got = 1'b1;
        break;
      end
    end
    total_cnt++;
    if (!got) begin
      $display("FAIL %s rx_valid timeout", name);
    end else if (exp_q.size() == 0) begin
      $display("FAIL %s unexpected byte got=%h", name, rx_data);
    end else begin
      e = exp_q.pop_front();
      if (rx_data !== e) $display("FAIL %s rx_data got=%h exp=%h", name, rx_data, e);
      else pass_cnt++;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 12 * D + 40 && tx_busy; i++) @(negedge clock);
    total_cnt++;
    if (tx_busy !== 1'b0) $display("FAIL idle_wait tx_busy got=%b exp=0", tx_busy);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tx_start = 1'b0;
    tx_data = 8'h00;
    loop_en = 1'b0;
    drv_rx = 1'b1;
    repeat (3) @(negedge clock);
    total_cnt++; if (ser_tx !== 1'b1) $display("FAIL rst_ser_tx got=%b exp=1", ser_tx); else pass_cnt++;
    total_cnt++; if (tx_busy !== 1'b0) $display("FAIL rst_tx_busy got=%b exp=0", tx_busy); else pass_cnt++;
    total_cnt++; if (tx_clear_req !== 1'b0) $display("FAIL rst_clear got=%b exp=0", tx_clear_req); else pass_cnt++;
    total_cnt++; if (rx_valid !== 1'b0) $display("FAIL rst_rx_valid got=%b exp=0", rx_valid); else pass_cnt++;
    total_cnt++; if (rx_err !== 1'b0) $display("FAIL rst_rx_err got=%b exp=0", rx_err); else pass_cnt++;
    total_cnt++; if (rx_data !== 8'h00) $display("FAIL rst_rx_data got=%h exp=00", rx_data); else pass_cnt++;
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_loopback();
    logic [7:0] msg [4];
    int v0;
    msg = '{8'h0F, 8'h3D, 8'h57, 8'h45};
    loop_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        total_cnt++;
        if (tx_clear_req !== 1'b1) $display("FAIL loop_clear_before[%0d] got=%b exp=1", i, tx_clear_req);
        else pass_cnt++;
      end
      v0 = vcount;
      exp_q.push_back(msg[i]);
      send_byte(msg[i]);
      total_cnt++;
      if (tx_clear_req !== 1'b0) $display("FAIL loop_clear_after[%0d] got=%b exp=0", i, tx_clear_req);
      else pass_cnt++;
      wait_rx("loop_byte");
      wait_idle();
      repeat (4) @(negedge clock);
      total_cnt++;
      if (vcount !== v0 + 1) $display("FAIL loop_valid_count[%0d] got=%0d exp=%0d", i, vcount - v0, 1);
      else pass_cnt++;
    end
    loop_en = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_tx_waveform();
    logic [9:0] f;
    logic bad;
    int busy_cnt;
    f = {1'b1, 8'h45, 1'b0};
    busy_cnt = 0;
    send_byte(8'h45);
    for (int k = 0; k < 10; k++) begin
      bad = 1'b0;
      for (int c = 0; c < D; c++) begin
        if (ser_tx !== f[k]) bad = 1'b1;
        if (tx_busy) busy_cnt++;
        @(negedge clock);
      end
      total_cnt++;
      if (bad) $display("FAIL wave_level[%0d] got=mismatch exp=%b", k, f[k]);
      else pass_cnt++;
    end
    for (int g = 0; g < 50 && tx_busy; g++) begin
      busy_cnt++;
      @(negedge clock);
    end
    total_cnt++;
    if (busy_cnt !== 10 * D) $display("FAIL wave_busy_len got=%0d exp=%0d", busy_cnt, 10 * D);
    else pass_cnt++;
    total_cnt++;
    if (ser_tx !== 1'b1) $display("FAIL wave_idle_line got=%b exp=1", ser_tx);
    else pass_cnt++;
  endtask

  task automatic test_held();
    int r0;
    r0 = busy_rises;
    @(negedge clock);
    tx_data = 8'h5A;
    tx_start = 1'b1;
    repeat (40) @(negedge clock);
    tx_start = 1'b0;
    @(negedge clock);
    tx_start = 1'b1;
    total_cnt++;
    if (tx_busy !== 1'b1) $display("FAIL held_busy_mid got=%b exp=1", tx_busy);
    else pass_cnt++;
    repeat (3 * 10 * D) @(negedge clock);
    total_cnt++;
    if (busy_rises - r0 !== 1) $display("FAIL held_frames got=%0d exp=1", busy_rises - r0);
    else pass_cnt++;
    total_cnt++;
    if (tx_busy !== 1'b0) $display("FAIL held_busy_end got=%b exp=0", tx_busy);
    else pass_cnt++;
    tx_start = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_framing();
    int v0;
    int e0;
    exp_q.push_back(8'h6C);
    fork
      drive_frame(8'h6C, 1'b1);
      wait_rx("frm_good");
    join
    total_cnt++;
    if (tx_clear_req !== 1'b1) $display("FAIL frm_clear_set got=%b exp=1", tx_clear_req);
    else pass_cnt++;
    v0 = vcount;
    e0 = ecount;
    @(negedge clock);
    drive_frame(8'hA5, 1'b0);
    repeat (2 * D) @(negedge clock);
    total_cnt++; if (ecount - e0 !== 1) $display("FAIL frm_err_count got=%0d exp=1", ecount - e0); else pass_cnt++;
    total_cnt++; if (vcount - v0 !== 0) $display("FAIL frm_valid_count got=%0d exp=0", vcount - v0); else pass_cnt++;
    total_cnt++; if (rx_data !== 8'h6C) $display("FAIL frm_rx_data got=%h exp=6c", rx_data); else pass_cnt++;
    total_cnt++; if (tx_clear_req !== 1'b1) $display("FAIL frm_clear_kept got=%b exp=1", tx_clear_req); else pass_cnt++;
  endtask

  task automatic test_glitch();
    int v0;
    int e0;
    v0 = vcount;
    e0 = ecount;
    @(negedge clock);
    drv_rx = 1'b0;
    repeat (3) @(negedge clock);
    drv_rx = 1'b1;
    repeat (2 * D) @(negedge clock);
    total_cnt++; if (vcount - v0 !== 0) $display("FAIL glitch_valid got=%0d exp=0", vcount - v0); else pass_cnt++;
    total_cnt++; if (ecount - e0 !== 0) $display("FAIL glitch_err got=%0d exp=0", ecount - e0); else pass_cnt++;
    exp_q.push_back(8'h3C);
    fork
      drive_frame(8'h3C, 1'b1);
      wait_rx("glitch_followup");
    join
    repeat (D) @(negedge clock);
  endtask

  task automatic test_reset_mid();
    send_byte(8'hC3);
    repeat (4 * D + D / 2) @(negedge clock);
    total_cnt++;
    if (ser_tx !== 1'b0 || tx_busy !== 1'b1) $display("FAIL mid_bit3 got=%b%b exp=01", ser_tx, tx_busy);
    else pass_cnt++;
    reset = 1'b1;
    @(negedge clock);
    total_cnt++; if (ser_tx !== 1'b1) $display("FAIL mid_rst_ser_tx got=%b exp=1", ser_tx); else pass_cnt++;
    total_cnt++; if (tx_busy !== 1'b0) $display("FAIL mid_rst_busy got=%b exp=0", tx_busy); else pass_cnt++;
    total_cnt++; if (tx_clear_req !== 1'b0) $display("FAIL mid_rst_clear got=%b exp=0", tx_clear_req); else pass_cnt++;
    total_cnt++;
    if (rx_valid !== 1'b0 || rx_err !== 1'b0) $display("FAIL mid_rst_flags got=%b%b exp=00", rx_valid, rx_err);
    else pass_cnt++;
    reset = 1'b0;
    repeat (3 * D) @(negedge clock);
    total_cnt++;
    if (ser_tx !== 1'b1 || tx_busy !== 1'b0) $display("FAIL mid_abandoned got=%b%b exp=10", ser_tx, tx_busy);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_tx_waveform();
    test_held();
    test_framing();
    test_glitch();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
